// File: rtl/stream_range_stats_if.sv
// Sample/result bundle for stream_range_stats; the DUT sits on the slave modport.
// Producer/consumer side uses master; result handshake is valid/ready.
interface stream_range_stats_if #(
    parameter int WIDTH     = 8,
    parameter int CNT_WIDTH = 8
);
    logic                 go;
    logic                 finish;
    logic                 in_valid;
    logic [WIDTH-1:0]     data_in;
    logic                 result_ready;
    logic                 result_valid;
    logic [WIDTH-1:0]     min_out;
    logic [WIDTH-1:0]     max_out;
    logic [WIDTH-1:0]     range;
    logic [CNT_WIDTH-1:0] count;
    logic                 count_sat;
    logic                 busy;
    logic                 error;

    modport slave (
        input  go, finish, in_valid, data_in, result_ready,
        output result_valid, min_out, max_out, range, count, count_sat, busy, error
    );

    modport master (
        output go, finish, in_valid, data_in, result_ready,
        input  result_valid, min_out, max_out, range, count, count_sat, busy, error
    );
endinterface

// File: rtl/stream_range_stats.sv
// Tracks min/max/range/count over a go..finish sample sequence; result registered one edge after finish.
// Result held in DONE until result_ready; no input backpressure (samples always accepted while running).
module stream_range_stats #(
    parameter int WIDTH     = 8,
    parameter int CNT_WIDTH = 8,
    parameter int SIGNED    = 0
) (
    input  logic                  clock,
    input  logic                  reset,
    stream_range_stats_if.slave   bus
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DONE  = 2'd2,
        ERROR = 2'd3
    } state_t;

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    state_t               r_state;
    logic [WIDTH-1:0]     r_min;
    logic [WIDTH-1:0]     r_max;
    logic [WIDTH-1:0]     r_range;
    logic [CNT_WIDTH-1:0] r_count;
    logic                 r_sat;
    logic                 r_result_valid;
    logic                 r_busy;
    logic                 r_error;

    state_t               w_state_nxt;
    logic [WIDTH-1:0]     w_min_nxt;
    logic [WIDTH-1:0]     w_max_nxt;
    logic [WIDTH-1:0]     w_range_nxt;
    logic [CNT_WIDTH-1:0] w_count_nxt;
    logic                 w_sat_nxt;

    logic                 w_lt;
    logic                 w_gt;
    logic [WIDTH-1:0]     w_acc_min;
    logic [WIDTH-1:0]     w_acc_max;
    logic [CNT_WIDTH-1:0] w_acc_count;
    logic                 w_acc_sat;

    // Strict compares: a sample equal to the current extreme leaves it untouched.
    always_comb begin
        if (SIGNED != 0) begin
            w_lt = $signed(bus.data_in) < $signed(r_min);
            w_gt = $signed(bus.data_in) > $signed(r_max);
        end else begin
            w_lt = bus.data_in < r_min;
            w_gt = bus.data_in > r_max;
        end
    end

    // Statistics with the current-cycle sample folded in (used only in RUN).
    always_comb begin
        w_acc_min   = r_min;
        w_acc_max   = r_max;
        w_acc_count = r_count;
        w_acc_sat   = r_sat;
        if (bus.in_valid) begin
            if (w_lt) w_acc_min = bus.data_in;
            if (w_gt) w_acc_max = bus.data_in;
            if (r_count != CNT_MAX) w_acc_count = r_count + 1'b1;
            w_acc_sat = r_sat | (w_acc_count == CNT_MAX);
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_min_nxt   = r_min;
        w_max_nxt   = r_max;
        w_range_nxt = r_range;
        w_count_nxt = r_count;
        w_sat_nxt   = r_sat;
        case (r_state)
            IDLE, ERROR: begin
                if (bus.go && !bus.finish) begin
                    w_state_nxt = RUN;
                    w_min_nxt   = bus.data_in;
                    w_max_nxt   = bus.data_in;
                    w_count_nxt = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
                    w_sat_nxt   = (CNT_MAX == {{(CNT_WIDTH-1){1'b0}}, 1'b1}) ? 1'b1 : 1'b0;
                    w_range_nxt = '0;
                end else if (bus.finish) begin
                    w_state_nxt = ERROR;
                    w_range_nxt = '0;
                end
            end
            RUN: begin
                if (bus.go) begin
                    // Restart attempt: sample in this cycle is dropped.
                    w_state_nxt = ERROR;
                end else begin
                    w_min_nxt   = w_acc_min;
                    w_max_nxt   = w_acc_max;
                    w_count_nxt = w_acc_count;
                    w_sat_nxt   = w_acc_sat;
                    if (bus.finish) begin
                        w_state_nxt = DONE;
                        w_range_nxt = w_acc_max - w_acc_min;
                    end
                end
            end
            DONE: begin
                if (bus.result_ready) w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state        <= IDLE;
            r_min          <= '0;
            r_max          <= '0;
            r_range        <= '0;
            r_count        <= '0;
            r_sat          <= 1'b0;
            r_result_valid <= 1'b0;
            r_busy         <= 1'b0;
            r_error        <= 1'b0;
        end else begin
            r_state        <= w_state_nxt;
            r_min          <= w_min_nxt;
            r_max          <= w_max_nxt;
            r_range        <= w_range_nxt;
            r_count        <= w_count_nxt;
            r_sat          <= w_sat_nxt;
            r_result_valid <= (w_state_nxt == DONE);
            r_busy         <= (w_state_nxt == RUN);
            r_error        <= (w_state_nxt == ERROR);
        end
    end

    assign bus.result_valid = r_result_valid;
    assign bus.min_out      = r_min;
    assign bus.max_out      = r_max;
    assign bus.range        = r_range;
    assign bus.count        = r_count;
    assign bus.count_sat    = r_sat;
    assign bus.busy         = r_busy;
    assign bus.error        = r_error;
endmodule

// File: tb/tb_stream_range_stats.sv
// Directed bench for stream_range_stats: unsigned, signed and narrow-counter instances on one clock.
module tb_stream_range_stats;
    logic clk;
    logic rst;
    int   tests;
    int   fails;

    stream_range_stats_if #(.WIDTH(8), .CNT_WIDTH(8)) bu ();
    stream_range_stats_if #(.WIDTH(8), .CNT_WIDTH(8)) bs ();
    stream_range_stats_if #(.WIDTH(8), .CNT_WIDTH(4)) bc ();

    stream_range_stats #(.WIDTH(8), .CNT_WIDTH(8), .SIGNED(0)) u_uns (.clock(clk), .reset(rst), .bus(bu));
    stream_range_stats #(.WIDTH(8), .CNT_WIDTH(8), .SIGNED(1)) u_sgn (.clock(clk), .reset(rst), .bus(bs));
    stream_range_stats #(.WIDTH(8), .CNT_WIDTH(4), .SIGNED(0)) u_cnt (.clock(clk), .reset(rst), .bus(bc));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        rst   = 1'b1;
        {bu.go, bu.finish, bu.in_valid, bu.data_in, bu.result_ready} = '0;
        {bs.go, bs.finish, bs.in_valid, bs.data_in, bs.result_ready} = '0;
        {bc.go, bc.finish, bc.in_valid, bc.data_in, bc.result_ready} = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_rv",    32'(bu.result_valid), 32'd0);
        check("rst_busy",  32'(bu.busy),         32'd0);
        check("rst_err",   32'(bu.error),        32'd0);
        check("rst_min",   32'(bu.min_out),      32'd0);
        check("rst_max",   32'(bu.max_out),      32'd0);
        check("rst_range", 32'(bu.range),        32'd0);
        check("rst_count", 32'(bu.count),        32'd0);
        check("rst_sat",   32'(bu.count_sat),    32'd0);
        rst = 1'b0;

        // Unsigned sequence: 50 then 10, 200, 90, finish without sample.
        bu.go = 1'b1; bu.data_in = 8'd50; bu.in_valid = 1'b0;
        tick;
        check("u_start_busy", 32'(bu.busy),    32'd1);
        check("u_start_min",  32'(bu.min_out), 32'd50);
        check("u_start_cnt",  32'(bu.count),   32'd1);
        bu.go = 1'b0; bu.in_valid = 1'b1;
        bu.data_in = 8'd10;  tick;
        bu.data_in = 8'd200; tick;
        bu.data_in = 8'd90;  tick;
        bu.in_valid = 1'b0; bu.finish = 1'b1;
        tick;
        bu.finish = 1'b0;
        check("u_rv",    32'(bu.result_valid), 32'd1);
        check("u_busy",  32'(bu.busy),         32'd0);
        check("u_min",   32'(bu.min_out),      32'd10);
        check("u_max",   32'(bu.max_out),      32'd200);
        check("u_range", 32'(bu.range),        32'd190);
        check("u_count", 32'(bu.count),        32'd4);

        // Consumer stalls for 5 cycles while the inputs are noisy.
        bu.in_valid = 1'b1; bu.data_in = 8'd0;
        for (int i = 0; i < 5; i++) begin
            bu.go = i[0];
            bu.finish = ~i[0];
            tick;
        end
        bu.go = 1'b0; bu.finish = 1'b0; bu.in_valid = 1'b0;
        check("hold_rv",    32'(bu.result_valid), 32'd1);
        check("hold_min",   32'(bu.min_out),      32'd10);
        check("hold_max",   32'(bu.max_out),      32'd200);
        check("hold_range", 32'(bu.range),        32'd190);
        check("hold_count", 32'(bu.count),        32'd4);
        bu.result_ready = 1'b1; bu.go = 1'b1; bu.data_in = 8'd5;
        tick;
        bu.result_ready = 1'b0; bu.go = 1'b0;
        check("acc_rv",   32'(bu.result_valid), 32'd0);
        check("acc_busy", 32'(bu.busy),         32'd0);
        check("acc_min",  32'(bu.min_out),      32'd10);
        tick;
        check("idle_busy", 32'(bu.busy), 32'd0);

        // Error paths.
        bu.finish = 1'b1; tick; bu.finish = 1'b0;
        check("e_idle_fin", 32'(bu.error), 32'd1);
        bu.go = 1'b1; bu.data_in = 8'd60; tick;
        check("e_restart1", 32'(bu.busy),  32'd1);
        bu.data_in = 8'd77; tick;
        bu.go = 1'b0;
        check("e_run_go",    32'(bu.error),   32'd1);
        check("e_run_range", 32'(bu.range),   32'd0);
        check("e_run_min",   32'(bu.min_out), 32'd60);
        bu.go = 1'b1; bu.data_in = 8'd33; tick;
        bu.go = 1'b0;
        check("e_rs_busy", 32'(bu.busy),    32'd1);
        check("e_rs_err",  32'(bu.error),   32'd0);
        check("e_rs_min",  32'(bu.min_out), 32'd33);
        check("e_rs_max",  32'(bu.max_out), 32'd33);
        check("e_rs_cnt",  32'(bu.count),   32'd1);

        // Reset while running.
        bu.in_valid = 1'b1; bu.data_in = 8'd99; tick;
        bu.in_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        check("mr_busy", 32'(bu.busy),    32'd0);
        check("mr_max",  32'(bu.max_out), 32'd0);
        check("mr_min",  32'(bu.min_out), 32'd0);
        check("mr_cnt",  32'(bu.count),   32'd0);
        #2 rst = 1'b0;
        tick;
        check("mr_rv",   32'(bu.result_valid), 32'd0);
        check("mr_idle", 32'(bu.busy),         32'd0);
        bu.finish = 1'b1; tick; bu.finish = 1'b0;
        check("mr_fin_err", 32'(bu.error), 32'd1);

        // Signed: -5, 7, then -20 alongside finish.
        bs.go = 1'b1; bs.data_in = 8'hFB; tick;
        bs.go = 1'b0; bs.in_valid = 1'b1; bs.data_in = 8'h07; tick;
        bs.finish = 1'b1; bs.data_in = 8'hEC; tick;
        bs.finish = 1'b0; bs.in_valid = 1'b0;
        check("s_rv",    32'(bs.result_valid), 32'd1);
        check("s_min",   32'(bs.min_out),      32'hEC);
        check("s_max",   32'(bs.max_out),      32'h07);
        check("s_range", 32'(bs.range),        32'd27);
        check("s_count", 32'(bs.count),        32'd3);
        bs.result_ready = 1'b1; tick; bs.result_ready = 1'b0;
        check("s_acc_rv", 32'(bs.result_valid), 32'd0);

        // 4-bit counter: go with 5, then 20 valid samples 100..119.
        bc.go = 1'b1; bc.data_in = 8'd5; tick;
        bc.go = 1'b0; bc.in_valid = 1'b1;
        for (int i = 0; i < 13; i++) begin
            bc.data_in = 8'(100 + i);
            tick;
        end
        check("c_cnt14", 32'(bc.count),     32'd14);
        check("c_sat0",  32'(bc.count_sat), 32'd0);
        for (int i = 13; i < 20; i++) begin
            bc.data_in = 8'(100 + i);
            tick;
        end
        bc.in_valid = 1'b0; bc.finish = 1'b1; tick; bc.finish = 1'b0;
        check("c_rv",    32'(bc.result_valid), 32'd1);
        check("c_count", 32'(bc.count),        32'd15);
        check("c_sat",   32'(bc.count_sat),    32'd1);
        check("c_min",   32'(bc.min_out),      32'd5);
        check("c_max",   32'(bc.max_out),      32'd119);
        check("c_range", 32'(bc.range),        32'd114);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
